// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 16x-oversampled UART receiver (start, 8 data LSB first,
// even parity, stop) feeding a 4-entry byte FIFO that is read through
// memory-mapped data and status registers.
module uart_rx_mmio #(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned BAUD_RATE = 2400,
  parameter int unsigned DATA_ADDR = 60,
  parameter int unsigned STAT_ADDR = 61
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [31:0] address,
  input  logic        mem_read,
  output logic [31:0] RD,
  output logic        rx_done,
  output logic        rx_irq
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  logic [1:0]    sync_q;
  logic          rxs_s;
  logic [TW-1:0] tcnt_q;
  logic          tick_s;

  state_t        state_q;
  logic [3:0]    scnt_q;
  logic [2:0]    bidx_q;
  logic [7:0]    shreg_q;
  logic          pbad_q;
  logic          push_q;
  logic          perr_set_q;
  logic          ferr_set_q;

  logic [7:0]    mem_q [4];
  logic [1:0]    wptr_q, wptr_d;
  logic [1:0]    rptr_q, rptr_d;
  logic [2:0]    count_q, count_d;
  logic          par_q, par_d;
  logic          frm_q, frm_d;
  logic          ovr_q, ovr_d;
  logic [31:0]   rd_q, rd_d;
  logic          rx_done_q;
  logic          rx_irq_q;

  logic          full_s, pop_s, wr_s, ovr_set_s, stat_rd_s, data_rd_s;

  assign rxs_s  = sync_q[1];
  assign tick_s = (tcnt_q == TMAX);

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  // Free-running oversample tick divider.
  always_ff @(posedge clk) begin
    if (!rst_n)      tcnt_q <= '0;
    else if (tick_s) tcnt_q <= '0;
    else             tcnt_q <= tcnt_q + TW'(1);
  end

  // Frame receiver FSM; produces one-cycle push and error-set pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      scnt_q     <= 4'd0;
      bidx_q     <= 3'd0;
      shreg_q    <= 8'd0;
      pbad_q     <= 1'b0;
      push_q     <= 1'b0;
      perr_set_q <= 1'b0;
      ferr_set_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      perr_set_q <= 1'b0;
      ferr_set_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxs_s) begin
            scnt_q  <= 4'd0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick_s) begin
            if (scnt_q == 4'd7) begin
              if (!rxs_s) begin
                scnt_q  <= 4'd0;
                bidx_q  <= 3'd0;
                state_q <= S_DATA;
              end else begin
                state_q <= S_IDLE;   // glitch, not a real start bit
              end
            end else begin
              scnt_q <= scnt_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick_s) begin
            scnt_q <= scnt_q + 4'd1;
            if (scnt_q == 4'd15) begin
              shreg_q <= {rxs_s, shreg_q[7:1]};
              bidx_q  <= bidx_q + 3'd1;
              if (bidx_q == 3'd7) state_q <= S_PAR;
            end
          end
        end
        S_PAR: begin
          if (tick_s) begin
            scnt_q <= scnt_q + 4'd1;
            if (scnt_q == 4'd15) begin
              pbad_q  <= (rxs_s != even_par(shreg_q));
              state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (tick_s) begin
            scnt_q <= scnt_q + 4'd1;
            if (scnt_q == 4'd15) begin
              if (pbad_q || !rxs_s) begin
                perr_set_q <= pbad_q;
                ferr_set_q <= !rxs_s;
              end else begin
                push_q <= 1'b1;
              end
              // Leaving at mid-stop lets a back-to-back start bit be seen.
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign full_s    = (count_q == 3'd4);
  assign data_rd_s = mem_read && (address == DATA_ADDR);
  assign stat_rd_s = mem_read && (address == STAT_ADDR);
  assign pop_s     = data_rd_s && (count_q != 3'd0);
  assign wr_s      = push_q && (!full_s || pop_s);
  assign ovr_set_s = push_q && full_s && !pop_s;

  // FIFO pointer/count, sticky flag and read-data next-state logic.
  always_comb begin
    wptr_d = wr_s  ? (wptr_q + 2'd1) : wptr_q;
    rptr_d = pop_s ? (rptr_q + 2'd1) : rptr_q;
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    // A new error in the clearing cycle must survive the clear.
    par_d = (par_q & ~stat_rd_s) | perr_set_q;
    frm_d = (frm_q & ~stat_rd_s) | ferr_set_q;
    ovr_d = (ovr_q & ~stat_rd_s) | ovr_set_s;
    if (data_rd_s) begin
      rd_d = {24'd0, (pop_s ? mem_q[rptr_q] : 8'd0)};
    end else if (stat_rd_s) begin
      rd_d = {26'd0, count_q, ovr_q, frm_q, par_q};
    end else begin
      rd_d = rd_q;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'd0;
    end else if (wr_s) begin
      mem_q[wptr_q] <= shreg_q;
    end else begin
      mem_q[wptr_q] <= mem_q[wptr_q];
    end
  end

  // FIFO control, sticky flags and registered MMIO outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= 2'd0;
      rptr_q    <= 2'd0;
      count_q   <= 3'd0;
      par_q     <= 1'b0;
      frm_q     <= 1'b0;
      ovr_q     <= 1'b0;
      rd_q      <= 32'd0;
      rx_done_q <= 1'b0;
      rx_irq_q  <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      par_q     <= par_d;
      frm_q     <= frm_d;
      ovr_q     <= ovr_d;
      rd_q      <= rd_d;
      rx_done_q <= wr_s;
      rx_irq_q  <= (count_d != 3'd0);
    end
  end

  assign RD      = rd_q;
  assign rx_done = rx_done_q;
  assign rx_irq  = rx_irq_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Testbench for uart_rx_mmio: directed vector table, hand-written corner
// sequences and randomized frames checked against a queue-based model.
module tb_uart_rx_mmio;

  localparam int unsigned CLK_FREQ  = 1000000;
  localparam int unsigned BAUD_RATE = 15625;            // DIV = 4
  localparam int unsigned DIV       = CLK_FREQ / (BAUD_RATE * 16);
  localparam int          BIT_CLKS  = 16 * DIV;
  localparam logic [31:0] DADDR     = 32'd60;
  localparam logic [31:0] SADDR     = 32'd61;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [31:0] address;
  logic        mem_read;
  logic [31:0] RD;
  logic        rx_done;
  logic        rx_irq;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_par, m_frm, m_ovr;
  int         m_done;

  uart_rx_mmio #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_ADDR(60), .STAT_ADDR(61)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .address(address), .mem_read(mem_read),
    .RD(RD), .rx_done(rx_done), .rx_irq(rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rx_done pulses away from the active edge.
  always @(negedge clk) if (rx_done === 1'b1) done_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic send_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  // A low stop bit is cut short so the trailing low only causes a false start.
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLKS);
    send_bit(par_bit, BIT_CLKS);
    if (stop_bit) send_bit(1'b1, BIT_CLKS);
    else begin
      send_bit(1'b0, 40);
      send_bit(1'b1, BIT_CLKS - 40);
    end
    send_bit(1'b1, BIT_CLKS);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] r);
    address  = a;
    mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    address  = 32'd0;
    r = RD;
  endtask

  // Model: apply one received frame by the frame rules.
  task automatic model_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    logic pbad;
    pbad = (par_bit != ^d);
    if (pbad || !stop_bit) begin
      if (pbad)      m_par = 1'b1;
      if (!stop_bit) m_frm = 1'b1;
    end else if (mq.size() == 4) begin
      m_ovr = 1'b1;
    end else begin
      mq.push_back(d);
      m_done++;
    end
  endtask

  function automatic logic [31:0] model_data_read();
    logic [7:0] v;
    if (mq.size() == 0) return 32'd0;
    v = mq.pop_front();
    return {24'd0, v};
  endfunction

  function automatic logic [31:0] model_stat_read();
    logic [31:0] v;
    int c;
    c = mq.size();
    v = {26'd0, 3'(c), m_ovr, m_frm, m_par};
    m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
    return v;
  endfunction

  typedef struct {
    logic [7:0]  data;
    logic        par_ok;
    logic        stop;
    int          exp_done;
    logic [31:0] exp_data;
    logic [31:0] exp_stat;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [31:0] r;
    int          d0;
    logic [7:0]  rd8;
    logic        pb, sb;
    int          kind, act;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 32'h0000_00A5, 32'h0000_0000};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 0, 32'h0000_0000, 32'h0000_0001};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 0, 32'h0000_0000, 32'h0000_0002};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1, 32'h0000_00FF, 32'h0000_0000};
    vecs[4] = '{8'h80, 1'b0, 1'b0, 0, 32'h0000_0000, 32'h0000_0003};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1, 32'h0000_0000, 32'h0000_0000};

    rx = 1'b1; address = 32'd0; mem_read = 1'b0; rst_n = 1'b0;
    m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0; m_done = 0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_RD", RD, 32'd0);
    chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
    chk("reset_rx_irq", {31'd0, rx_irq}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      pb = vecs[i].par_ok ? ^vecs[i].data : ~(^vecs[i].data);
      send_frame(vecs[i].data, pb, vecs[i].stop);
      chk($sformatf("vec%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      do_read(DADDR, r);
      chk($sformatf("vec%0d_data", i), r, vecs[i].exp_data);
      do_read(SADDR, r);
      chk($sformatf("vec%0d_stat", i), r, vecs[i].exp_stat);
    end
    do_read(SADDR, r);
    chk("stat_cleared", r, 32'd0);

    // Overrun: five good frames, no reads
    d0 = done_cnt;
    for (int i = 1; i <= 5; i++) begin
      rd8 = 8'(i * 8'h11);
      send_frame(rd8, ^rd8, 1'b1);
    end
    chk("ovr_done", 32'(done_cnt - d0), 32'd4);
    chk("ovr_irq", {31'd0, rx_irq}, 32'd1);
    do_read(SADDR, r);
    chk("ovr_stat", r, 32'h0000_0024);
    for (int i = 1; i <= 4; i++) begin
      do_read(DADDR, r);
      chk($sformatf("ovr_data%0d", i), r, 32'(i * 8'h11));
      if (i == 1) begin
        do_read(32'd5, r);
        chk("other_addr_hold", r, 32'h0000_0011);
      end
    end
    do_read(DADDR, r);
    chk("ovr_data_empty", r, 32'd0);
    chk("ovr_irq_clear", {31'd0, rx_irq}, 32'd0);

    // False start: low for 3 ticks only
    d0 = done_cnt;
    send_bit(1'b0, 3 * DIV);
    send_bit(1'b1, 2 * BIT_CLKS);
    chk("false_start_done", 32'(done_cnt - d0), 32'd0);
    do_read(SADDR, r);
    chk("false_start_stat", r, 32'd0);

    // Reset during data bit 4 with a byte already queued
    send_frame(8'h33, ^(8'h33), 1'b1);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) send_bit(d0[0] ^ d0[0] ^ (8'h5A >> i) & 1'b1, BIT_CLKS);
    send_bit(1'b1, BIT_CLKS / 2);   // bit 4 of 0x5A is 1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1, 2 * BIT_CLKS);
    d0 = done_cnt;
    send_frame(8'h7E, ^(8'h7E), 1'b1);
    chk("rst_mid_done", 32'(done_cnt - d0), 32'd1);
    do_read(SADDR, r);
    chk("rst_mid_stat", r, 32'h0000_0008);
    do_read(DADDR, r);
    chk("rst_mid_data", r, 32'h0000_007E);
    do_read(DADDR, r);
    chk("rst_mid_empty", r, 32'd0);

    // Randomized frames against the model (FIFO empty, flags clear here)
    mq.delete();
    m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0; m_done = 0;
    d0 = done_cnt;
    for (int i = 0; i < 24; i++) begin
      rd8  = 8'($urandom);
      kind = $urandom_range(0, 9);
      pb   = (kind == 0 || kind == 2) ? ~(^rd8) : ^rd8;
      sb   = (kind == 1 || kind == 2) ? 1'b0 : 1'b1;
      send_frame(rd8, pb, sb);
      model_frame(rd8, pb, sb);
      chk($sformatf("rnd%0d_irq", i), {31'd0, rx_irq}, {31'd0, (mq.size() != 0)});
      act = $urandom_range(0, 3);
      if (act == 0 || act == 2) begin
        do_read(DADDR, r);
        chk($sformatf("rnd%0d_data", i), r, model_data_read());
      end
      if (act == 1 || act == 2) begin
        do_read(SADDR, r);
        chk($sformatf("rnd%0d_stat", i), r, model_stat_read());
      end
    end
    chk("rnd_done_total", 32'(done_cnt - d0), 32'(m_done));
    do_read(SADDR, r);
    chk("rnd_final_stat", r, model_stat_read());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
